// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receive path: FSM states, frame size
// and the odd-parity test applied to each received byte.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int PS2_FRAME_BITS = 11;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Small synchronous FIFO for received scan-code bytes. The parent decides
// whether a push is allowed; this block stores whatever it is told to push.
module ps2_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             pop_ok;

    assign empty  = (level_q == '0);
    assign full   = (level_q == LW'(DEPTH));
    assign head   = mem_q[rd_ptr_q];
    assign level  = level_q;
    assign pop_ok = pop & ~empty;

    // When full with push and pop together, the write lands in the slot being
    // vacated by the pop, which becomes the new tail once rd_ptr advances.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise and filter ps2c, deframe and check
// 11-bit frames, abort stalled frames, and queue good bytes behind valid/ready.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int FIFO_DEPTH     = 4,
    parameter int CHECK_PARITY   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2c,
    input  logic                          ps2d,
    input  logic                          rx_en,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [7:0]                    rx_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          timeout_err,
    output logic                          overflow_err
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic                  ps2c_meta_q, ps2c_meta_d, ps2c_sync_q, ps2c_sync_d;
    logic                  ps2d_meta_q, ps2d_meta_d, ps2d_sync_q, ps2d_sync_d;
    logic [FILTER_LEN-1:0] filt_sr_q, filt_sr_d;
    logic                  filt_val_q, filt_val_d;
    logic                  neg_edge;
    state_t                state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [9:0]            shreg_q, shreg_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  parity_err_q, parity_err_d, frame_err_q, frame_err_d;
    logic                  timeout_err_q, timeout_err_d, overflow_err_q, overflow_err_d;
    logic                  push, pop, fifo_full, fifo_empty;

    assign rx_valid     = ~fifo_empty;
    assign pop          = rx_valid & rx_ready;
    assign parity_err   = parity_err_q;
    assign frame_err    = frame_err_q;
    assign timeout_err  = timeout_err_q;
    assign overflow_err = overflow_err_q;

    // The filter only changes value once the whole window agrees, so ps2c
    // glitches shorter than FILTER_LEN samples never produce an edge.
    always_comb begin
        ps2c_meta_d = ps2c;
        ps2c_sync_d = ps2c_meta_q;
        ps2d_meta_d = ps2d;
        ps2d_sync_d = ps2d_meta_q;
        filt_sr_d   = {filt_sr_q[FILTER_LEN-2:0], ps2c_sync_q};
        filt_val_d  = filt_val_q;
        if (&filt_sr_q) begin
            filt_val_d = 1'b1;
        end else if (~|filt_sr_q) begin
            filt_val_d = 1'b0;
        end
        neg_edge = filt_val_q & ~filt_val_d;
    end

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shreg_d        = shreg_q;
        wd_d           = wd_q;
        push           = 1'b0;
        parity_err_d   = 1'b0;
        frame_err_d    = 1'b0;
        timeout_err_d  = 1'b0;
        overflow_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                wd_d = '0;
                if (neg_edge && rx_en && !ps2d_sync_q) begin
                    state_d   = SHIFT;
                    bit_cnt_d = 4'(PS2_FRAME_BITS - 1);
                end
            end
            SHIFT: begin
                if (neg_edge) begin
                    shreg_d   = {ps2d_sync_q, shreg_q[9:1]};
                    bit_cnt_d = bit_cnt_q - 4'd1;
                    wd_d      = '0;
                    if (bit_cnt_q == 4'd1) state_d = CHECK;
                end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            CHECK: begin
                // shreg holds {stop, parity, data[7:0]} once all ten bits are in.
                state_d = IDLE;
                if (!shreg_q[9]) begin
                    frame_err_d = 1'b1;
                end else if (CHECK_PARITY != 0 && !odd_parity_ok(shreg_q[7:0], shreg_q[8])) begin
                    parity_err_d = 1'b1;
                end else if (fifo_full && !pop) begin
                    overflow_err_d = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps2c_meta_q    <= 1'b1;
            ps2c_sync_q    <= 1'b1;
            ps2d_meta_q    <= 1'b1;
            ps2d_sync_q    <= 1'b1;
            filt_sr_q      <= '1;
            filt_val_q     <= 1'b1;
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            shreg_q        <= '0;
            wd_q           <= '0;
            parity_err_q   <= 1'b0;
            frame_err_q    <= 1'b0;
            timeout_err_q  <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            ps2c_meta_q    <= ps2c_meta_d;
            ps2c_sync_q    <= ps2c_sync_d;
            ps2d_meta_q    <= ps2d_meta_d;
            ps2d_sync_q    <= ps2d_sync_d;
            filt_sr_q      <= filt_sr_d;
            filt_val_q     <= filt_val_d;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shreg_q        <= shreg_d;
            wd_q           <= wd_d;
            parity_err_q   <= parity_err_d;
            frame_err_q    <= frame_err_d;
            timeout_err_q  <= timeout_err_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    ps2_byte_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(shreg_q[7:0]),
        .pop      (pop),
        .head     (rx_data),
        .level    (fifo_level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule
